// File: rtl/f_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : f_fetch_unit
// Function : Fetch-stage PC register, next-PC select, AdEL detection, F outputs
// Revision : 1.0
// ============================================================================
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        BUSY,
  input  logic        start,
  input  logic        Req,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        D_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] INSTR_F,
  output logic [31:0] PC4_F,
  output logic [3:0]  F_ExcCode,
  output logic        BD_F
);

  localparam logic [3:0] C_EXC_NONE = 4'd0;
  localparam logic [3:0] C_EXC_ADEL = 4'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        w_en;
  logic        w_exc_f;

  assign w_en = !(stall | BUSY | start);

  // Req redirects even through a stall; eret outranks a branch/jump.
  always_comb begin
    pc_d = pc_q;
    if (Req) begin
      pc_d = HANDLER_PC;
    end else if (w_en) begin
      if (eret_D) begin
        pc_d = EPC;
      end else if (npc_sel) begin
        pc_d = npc_target;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign w_exc_f = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

  assign i_inst_addr = pc_q;
  assign PC4_F       = pc_q + 32'd4;
  assign F_ExcCode   = w_exc_f ? C_EXC_ADEL : C_EXC_NONE;
  // eret has no delay slot: kill the sequential fetch behind it.
  assign INSTR_F     = (w_exc_f || eret_D) ? 32'd0 : i_inst_rdata;
  assign BD_F        = D_is_jump && !eret_D;

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_fetch_unit
// Function : Directed self-checking bench for f_fetch_unit
// Revision : 1.0
// ============================================================================
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, BUSY, start, Req, eret_D, npc_sel, D_is_jump;
  logic [31:0] EPC, npc_target;
  logic [31:0] i_inst_addr, i_inst_rdata, INSTR_F, PC4_F;
  logic [3:0]  F_ExcCode;
  logic        BD_F;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: data is a fixed function of the address.
  assign i_inst_rdata = {i_inst_addr[15:0], 16'hA5C3};

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], 16'hA5C3};
  endfunction

  f_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .BUSY(BUSY), .start(start),
    .Req(Req), .eret_D(eret_D), .EPC(EPC), .npc_sel(npc_sel),
    .npc_target(npc_target), .D_is_jump(D_is_jump),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .INSTR_F(INSTR_F), .PC4_F(PC4_F), .F_ExcCode(F_ExcCode), .BD_F(BD_F)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; BUSY = 0; start = 0; Req = 0; eret_D = 0;
    npc_sel = 0; D_is_jump = 0; EPC = 32'h0; npc_target = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    D_is_jump = 1;
    reset = 0;
    tick(); tick();
    checks++; if (i_inst_addr !== 32'h3000) begin errors++; $display("FAIL reset_addr: got %h want %h", i_inst_addr, 32'h3000); end
    checks++; if (PC4_F !== 32'h3004) begin errors++; $display("FAIL reset_pc4: got %h want %h", PC4_F, 32'h3004); end
    checks++; if (F_ExcCode !== 4'd0) begin errors++; $display("FAIL reset_exc: got %0d want 0", F_ExcCode); end
    checks++; if (BD_F !== 1'b1) begin errors++; $display("FAIL reset_bd: got %b want 1", BD_F); end
    checks++; if (INSTR_F !== mem(32'h3000)) begin errors++; $display("FAIL reset_instr: got %h want %h", INSTR_F, mem(32'h3000)); end
    D_is_jump = 0;
    reset = 1;
    #1;
    checks++; if (i_inst_addr !== 32'h3000) begin errors++; $display("FAIL release_addr: got %h want %h", i_inst_addr, 32'h3000); end
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (i_inst_addr !== 32'h3004) begin errors++; $display("FAIL seq_addr1: got %h want %h", i_inst_addr, 32'h3004); end
    tick();
    checks++; if (i_inst_addr !== 32'h3008) begin errors++; $display("FAIL seq_addr2: got %h want %h", i_inst_addr, 32'h3008); end
    checks++; if (PC4_F !== 32'h300c) begin errors++; $display("FAIL seq_pc4: got %h want %h", PC4_F, 32'h300c); end
    checks++; if (INSTR_F !== mem(32'h3008)) begin errors++; $display("FAIL seq_instr: got %h want %h", INSTR_F, mem(32'h3008)); end
    tick(); tick();
  endtask

  task automatic test_stall();
    checks++; if (i_inst_addr !== 32'h3010) begin errors++; $display("FAIL stall_pre: got %h want %h", i_inst_addr, 32'h3010); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (i_inst_addr !== 32'h3010) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, i_inst_addr, 32'h3010); end
    end
    stall = 0; BUSY = 1;
    tick();
    checks++; if (i_inst_addr !== 32'h3010) begin errors++; $display("FAIL busy_hold: got %h want %h", i_inst_addr, 32'h3010); end
    BUSY = 0; start = 1;
    tick();
    checks++; if (i_inst_addr !== 32'h3010) begin errors++; $display("FAIL start_hold: got %h want %h", i_inst_addr, 32'h3010); end
    start = 0;
    tick();
    checks++; if (i_inst_addr !== 32'h3014) begin errors++; $display("FAIL stall_release: got %h want %h", i_inst_addr, 32'h3014); end
  endtask

  task automatic test_branch();
    tick(); tick(); tick();
    checks++; if (i_inst_addr !== 32'h3020) begin errors++; $display("FAIL br_pre: got %h want %h", i_inst_addr, 32'h3020); end
    npc_sel = 1; npc_target = 32'h3100; D_is_jump = 1;
    #1;
    checks++; if (BD_F !== 1'b1) begin errors++; $display("FAIL br_bd: got %b want 1", BD_F); end
    tick();
    checks++; if (i_inst_addr !== 32'h3100) begin errors++; $display("FAIL br_target: got %h want %h", i_inst_addr, 32'h3100); end
    clear_inputs();
    #1;
    checks++; if (BD_F !== 1'b0) begin errors++; $display("FAIL br_bd_clear: got %b want 0", BD_F); end
  endtask

  task automatic test_req();
    npc_sel = 1; npc_target = 32'h3040;
    tick();
    npc_sel = 0;
    stall = 1; Req = 1;
    tick();
    checks++; if (i_inst_addr !== 32'h4180) begin errors++; $display("FAIL req_stall: got %h want %h", i_inst_addr, 32'h4180); end
    checks++; if (F_ExcCode !== 4'd0) begin errors++; $display("FAIL req_exc: got %0d want 0", F_ExcCode); end
    clear_inputs();
    tick();
    #2 reset = 0;
    #1;
    checks++; if (i_inst_addr !== 32'h3000) begin errors++; $display("FAIL async_reset: got %h want %h", i_inst_addr, 32'h3000); end
    reset = 1;
    // Req beats a pending illegal target.
    npc_sel = 1; npc_target = 32'h3002; Req = 1;
    tick();
    checks++; if (i_inst_addr !== 32'h4180) begin errors++; $display("FAIL req_vs_target: got %h want %h", i_inst_addr, 32'h4180); end
    clear_inputs();
  endtask

  task automatic test_eret();
    eret_D = 1; EPC = 32'h3058; npc_sel = 1; npc_target = 32'h3100; D_is_jump = 1;
    #1;
    checks++; if (INSTR_F !== 32'h0) begin errors++; $display("FAIL eret_instr: got %h want 0", INSTR_F); end
    checks++; if (BD_F !== 1'b0) begin errors++; $display("FAIL eret_bd: got %b want 0", BD_F); end
    tick();
    checks++; if (i_inst_addr !== 32'h3058) begin errors++; $display("FAIL eret_pc: got %h want %h", i_inst_addr, 32'h3058); end
    // eret under stall must hold.
    stall = 1; EPC = 32'h3200;
    tick();
    checks++; if (i_inst_addr !== 32'h3058) begin errors++; $display("FAIL eret_stall: got %h want %h", i_inst_addr, 32'h3058); end
    clear_inputs();
  endtask

  task automatic test_adel();
    npc_sel = 1; npc_target = 32'h3002;
    tick();
    checks++; if (F_ExcCode !== 4'd4) begin errors++; $display("FAIL adel_misalign: got %0d want 4", F_ExcCode); end
    checks++; if (INSTR_F !== 32'h0) begin errors++; $display("FAIL adel_instr: got %h want 0", INSTR_F); end
    npc_sel = 0;
    tick();
    checks++; if (i_inst_addr !== 32'h3006) begin errors++; $display("FAIL adel_advance: got %h want %h", i_inst_addr, 32'h3006); end
    npc_sel = 1; npc_target = 32'h7000;
    tick();
    checks++; if (F_ExcCode !== 4'd4) begin errors++; $display("FAIL adel_high: got %0d want 4", F_ExcCode); end
    npc_target = 32'h2ffc;
    tick();
    checks++; if (F_ExcCode !== 4'd4) begin errors++; $display("FAIL adel_low: got %0d want 4", F_ExcCode); end
    npc_target = 32'h6ffc;
    tick();
    checks++; if (F_ExcCode !== 4'd0) begin errors++; $display("FAIL adel_top_ok: got %0d want 0", F_ExcCode); end
    checks++; if (INSTR_F !== mem(32'h6ffc)) begin errors++; $display("FAIL adel_top_instr: got %h want %h", INSTR_F, mem(32'h6ffc)); end
    npc_target = 32'h3000;
    tick();
    checks++; if (F_ExcCode !== 4'd0) begin errors++; $display("FAIL adel_bottom_ok: got %0d want 0", F_ExcCode); end
    npc_sel = 0;
    clear_inputs();
  endtask

  task automatic test_wrap();
    npc_sel = 1; npc_target = 32'hffff_fffc;
    tick();
    npc_sel = 0;
    checks++; if (PC4_F !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", PC4_F); end
    checks++; if (F_ExcCode !== 4'd4) begin errors++; $display("FAIL wrap_exc_pre: got %0d want 4", F_ExcCode); end
    tick();
    checks++; if (i_inst_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", i_inst_addr); end
    checks++; if (F_ExcCode !== 4'd4) begin errors++; $display("FAIL wrap_exc: got %0d want 4", F_ExcCode); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_req();
    test_eret();
    test_adel();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
